// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: load funct3 codes, source select and write request.
package riscv_wb_pkg;

    localparam int WB_XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_HOLD,
        WB_LOAD
    } wb_src_e;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

    // Load-sourced writes are the only ones that retire a scoreboard entry.
    function automatic logic is_load_src(input wb_src_e src);
        return (src == WB_HOLD) || (src == WB_LOAD);
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU result, load issue/response, register-file write and perf signals around wb_arbiter.
interface wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            ld_issue_valid;
    logic [4:0]      ld_issue_rd;

    logic            ld_rsp_valid;
    logic            ld_rsp_ready;
    logic [4:0]      ld_rsp_rd;
    logic [2:0]      ld_rsp_funct3;
    logic [1:0]      ld_rsp_offset;
    logic [XLEN-1:0] ld_rsp_data;

    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     busy;

    logic [31:0]     perf_alu_wr;
    logic [31:0]     perf_ld_wr;
    logic [31:0]     perf_ld_stall;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue_valid, ld_issue_rd,
        input  ld_rsp_valid, ld_rsp_rd, ld_rsp_funct3, ld_rsp_offset, ld_rsp_data,
        output ld_rsp_ready,
        output rf_we, rf_waddr, rf_wdata, busy,
        output perf_alu_wr, perf_ld_wr, perf_ld_stall
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue_valid, ld_issue_rd,
        output ld_rsp_valid, ld_rsp_rd, ld_rsp_funct3, ld_rsp_offset, ld_rsp_data,
        input  ld_rsp_ready,
        input  rf_we, rf_waddr, rf_wdata, busy,
        input  perf_alu_wr, perf_ld_wr, perf_ld_stall
    );

endinterface

// File: rtl/wb_arbiter_load_align.sv
// Combinational load formatter: selects byte/half from an aligned word and sign/zero-extends it.
module load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [7:0]      bs;
        logic signed [XLEN-1:0] ws;
        bs = b;
        ws = XLEN'(bs);
        return sgn ? ws : {{(XLEN-8){1'b0}}, b};
    endfunction

    function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [15:0]     hs;
        logic signed [XLEN-1:0] ws;
        hs = h;
        ws = XLEN'(hs);
        return sgn ? ws : {{(XLEN-16){1'b0}}, h};
    endfunction

    // Unknown funct3 codes fall back to a full-word load.
    function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3, input logic [7:0] b,
                                                    input logic [15:0] h, input logic [XLEN-1:0] w);
        case (f3)
            F3_LB:   return ext8(b, 1'b1);
            F3_LBU:  return ext8(b, 1'b0);
            F3_LH:   return ext16(h, 1'b1);
            F3_LHU:  return ext16(h, 1'b0);
            default: return w;
        endcase
    endfunction

    always_comb begin
        byte_sel = raw[7:0];
        case (offset)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = offset[1] ? raw[31:16] : raw[15:0];
        data     = format_load(funct3, byte_sel, half_sel, raw);
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and LSU load responses onto the register-file write port.
// Define WB_PERF_EN to build the write/stall performance counters; otherwise they read 0.
module wb_arbiter
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);

    logic            ld_acc_p0;
    logic [XLEN-1:0] ld_fmt_p0;
    wb_req_t         ld_req_p0;
    wb_src_e         src_p0;
    wb_req_t         sel_p0;
    logic [31:0]     busy_nxt_p0;

    logic            hold_full_p1;
    wb_req_t         hold_p1;
    logic            vld_p1;
    logic [4:0]      waddr_p1;
    logic [XLEN-1:0] wdata_p1;
    logic [31:0]     busy_p1;

    load_align #(.XLEN(XLEN)) u_align (
        .funct3 (bus.ld_rsp_funct3),
        .offset (bus.ld_rsp_offset),
        .raw    (bus.ld_rsp_data),
        .data   (ld_fmt_p0)
    );

    // Stage p0: source selection; ready depends only on hold occupancy.
    assign bus.ld_rsp_ready = !hold_full_p1;
    assign ld_acc_p0        = bus.ld_rsp_valid && !hold_full_p1;
    assign ld_req_p0        = '{rd: bus.ld_rsp_rd, data: ld_fmt_p0};

    always_comb begin
        src_p0 = WB_NONE;
        sel_p0 = '0;
        if (bus.alu_valid) begin
            src_p0 = WB_ALU;
            sel_p0 = '{rd: bus.alu_rd, data: bus.alu_data};
        end else if (hold_full_p1) begin
            src_p0 = WB_HOLD;
            sel_p0 = hold_p1;
        end else if (ld_acc_p0) begin
            src_p0 = WB_LOAD;
            sel_p0 = ld_req_p0;
        end
    end

    // Set is applied after clear so a re-issue on the retiring edge keeps the bit.
    always_comb begin
        busy_nxt_p0 = busy_p1;
        if (is_load_src(src_p0)) begin
            busy_nxt_p0[sel_p0.rd] = 1'b0;
        end
        if (bus.ld_issue_valid) begin
            busy_nxt_p0[bus.ld_issue_rd] = 1'b1;
        end
        busy_nxt_p0[0] = 1'b0;
    end

    // Stage p1: hold buffer, registered write port and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_p1 <= 1'b0;
        end else if (ld_acc_p0 && bus.alu_valid) begin
            hold_full_p1 <= 1'b1;
        end else if (hold_full_p1 && !bus.alu_valid) begin
            hold_full_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_acc_p0 && bus.alu_valid) begin
            hold_p1 <= ld_req_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
            busy_p1  <= '0;
        end else begin
            vld_p1  <= (src_p0 != WB_NONE) && (sel_p0.rd != 5'd0);
            busy_p1 <= busy_nxt_p0;
            if (src_p0 != WB_NONE) begin
                waddr_p1 <= sel_p0.rd;
                wdata_p1 <= sel_p0.data;
            end
        end
    end

    assign bus.rf_we    = vld_p1;
    assign bus.rf_waddr = waddr_p1;
    assign bus.rf_wdata = wdata_p1;
    assign bus.busy     = busy_p1;

`ifdef WB_PERF_EN
    logic [31:0] perf_alu_p1;
    logic [31:0] perf_ld_p1;
    logic [31:0] perf_stall_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_alu_p1   <= '0;
            perf_ld_p1    <= '0;
            perf_stall_p1 <= '0;
        end else begin
            if (src_p0 == WB_ALU && sel_p0.rd != 5'd0) begin
                perf_alu_p1 <= perf_alu_p1 + 32'd1;
            end
            if (is_load_src(src_p0) && sel_p0.rd != 5'd0) begin
                perf_ld_p1 <= perf_ld_p1 + 32'd1;
            end
            if (bus.ld_rsp_valid && hold_full_p1) begin
                perf_stall_p1 <= perf_stall_p1 + 32'd1;
            end
        end
    end

    assign bus.perf_alu_wr   = perf_alu_p1;
    assign bus.perf_ld_wr    = perf_ld_p1;
    assign bus.perf_ld_stall = perf_stall_p1;
`else
    assign bus.perf_alu_wr   = '0;
    assign bus.perf_ld_wr    = '0;
    assign bus.perf_ld_stall = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes are queued by the stimulus and
// popped by an independent monitor; flag-style outputs are checked inline.
module tb_wb_arbiter;
    import riscv_wb_pkg::*;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [36:0] exp_q[$];
    logic [36:0] mon_exp;

    localparam logic [31:0] RAW = 32'h80FF7F01;
    logic [2:0]  vec_f3  [12] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011,
                                  3'b001, 3'b000, 3'b101, 3'b111, 3'b000, 3'b001};
    logic [1:0]  vec_off [12] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0,
                                  2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    logic [31:0] vec_exp [12] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                                  32'h80FF7F01, 32'h80FF7F01, 32'hFFFF80FF, 32'h0000007F,
                                  32'h000080FF, 32'h80FF7F01, 32'hFFFFFF80, 32'h00007F01};

    wb_arbiter_if #(.XLEN(32)) bus ();

    wb_arbiter #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid      = 1'b0;
        bus.ld_issue_valid = 1'b0;
        bus.ld_rsp_valid   = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] d);
        bus.ld_rsp_valid  = 1'b1;
        bus.ld_rsp_rd     = rd;
        bus.ld_rsp_funct3 = f3;
        bus.ld_rsp_offset = off;
        bus.ld_rsp_data   = d;
    endtask

    task automatic drive_issue(input logic [4:0] rd);
        bus.ld_issue_valid = 1'b1;
        bus.ld_issue_rd    = rd;
    endtask

    // Monitor: every registered write must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rf_write_unexpected: got x%0d=0x%0h, expected no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rf_write", 64'({bus.rf_waddr, bus.rf_wdata}), 64'(mon_exp));
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.alu_rd = '0; bus.alu_data = '0; bus.ld_issue_rd = '0;
        bus.ld_rsp_rd = '0; bus.ld_rsp_funct3 = '0; bus.ld_rsp_offset = '0; bus.ld_rsp_data = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("reset_we",    64'(bus.rf_we),        64'd0);
        check("reset_waddr", 64'(bus.rf_waddr),     64'd0);
        check("reset_wdata", 64'(bus.rf_wdata),     64'd0);
        check("reset_busy",  64'(bus.busy),         64'd0);
        check("reset_ready", 64'(bus.ld_rsp_ready), 64'd1);

        // ALU path, including x0 suppression
        drive_alu(5'd5, 32'hDEADBEEF);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        check("alu_latency_we", 64'(bus.rf_we),    64'd1);
        check("alu_waddr",      64'(bus.rf_waddr), 64'd5);
        drive_alu(5'd0, 32'h00001234);
        tick();
        idle();
        check("alu_x0_we", 64'(bus.rf_we), 64'd0);
        tick();

        // Load formatting, back to back
        for (int i = 0; i < 12; i++) begin
            drive_ld(5'(10 + i), vec_f3[i], vec_off[i], RAW);
            expect_wr(5'(10 + i), vec_exp[i]);
            tick();
        end
        idle();
        check("fmt_ready", 64'(bus.ld_rsp_ready), 64'd1);
        tick();

        // Load to x0 is consumed without a write
        drive_ld(5'd0, F3_LW, 2'd0, 32'h12345678);
        tick();
        idle();
        check("ld_x0_we",    64'(bus.rf_we),        64'd0);
        check("ld_x0_ready", 64'(bus.ld_rsp_ready), 64'd1);
        tick();

        // ALU/load collision
        drive_alu(5'd3, 32'h00000033);
        drive_ld(5'd7, F3_LW, 2'd0, 32'h77777777);
        expect_wr(5'd3, 32'h00000033);
        expect_wr(5'd7, 32'h77777777);
        tick();
        idle();
        check("coll_ready_lo", 64'(bus.ld_rsp_ready), 64'd0);
        check("coll_waddr_alu", 64'(bus.rf_waddr),   64'd3);
        tick();
        check("coll_ready_hi", 64'(bus.ld_rsp_ready), 64'd1);
        check("coll_waddr_hold", 64'(bus.rf_waddr),  64'd7);
        check("coll_hold_we",  64'(bus.rf_we),       64'd1);

        // Hold stays full across a run of ALU writes
        drive_alu(5'd1, 32'h00000101);
        drive_ld(5'd8, F3_LHU, 2'd2, RAW);
        expect_wr(5'd1, 32'h00000101);
        tick();
        bus.ld_rsp_valid = 1'b0;
        check("run_ready_0", 64'(bus.ld_rsp_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive_alu(5'(20 + i), 32'(32'hA0 + i));
            expect_wr(5'(20 + i), 32'(32'hA0 + i));
            tick();
            check("run_ready_lo", 64'(bus.ld_rsp_ready), 64'd0);
        end
        expect_wr(5'd8, 32'h000080FF);
        idle();
        tick();
        check("run_drain_ready", 64'(bus.ld_rsp_ready), 64'd1);
        check("run_drain_waddr", 64'(bus.rf_waddr),     64'd8);

        // Scoreboard set/clear and set-wins
        drive_issue(5'd9);
        tick();
        idle();
        check("sb_set", 64'(bus.busy), 64'(32'h1 << 9));
        drive_ld(5'd9, F3_LW, 2'd0, 32'h99999999);
        expect_wr(5'd9, 32'h99999999);
        tick();
        idle();
        check("sb_clear_busy", 64'(bus.busy),  64'd0);
        check("sb_clear_we",   64'(bus.rf_we), 64'd1);
        drive_issue(5'd9);
        tick();
        drive_ld(5'd9, F3_LB, 2'd3, RAW);
        expect_wr(5'd9, 32'hFFFFFF80);
        tick();
        idle();
        check("sb_set_wins", 64'(bus.busy), 64'(32'h1 << 9));
        drive_ld(5'd9, F3_LBU, 2'd1, RAW);
        expect_wr(5'd9, 32'h0000007F);
        tick();
        idle();
        check("sb_clear2", 64'(bus.busy), 64'd0);
        drive_issue(5'd0);
        tick();
        idle();
        check("sb_x0", 64'(bus.busy), 64'd0);

        // Scoreboard clears only when a held load drains; ALU writes leave it alone
        drive_issue(5'd12);
        tick();
        drive_issue(5'd15);
        drive_alu(5'd2, 32'h00000022);
        drive_ld(5'd12, F3_LW, 2'd0, 32'h0000C0C0);
        expect_wr(5'd2, 32'h00000022);
        tick();
        idle();
        check("sb_hold_pending", 64'(bus.busy), 64'((32'h1 << 12) | (32'h1 << 15)));
        drive_alu(5'd15, 32'h0000000F);
        expect_wr(5'd15, 32'h0000000F);
        expect_wr(5'd12, 32'h0000C0C0);
        tick();
        idle();
        check("sb_alu_no_clear", 64'(bus.busy), 64'((32'h1 << 12) | (32'h1 << 15)));
        tick();
        check("sb_hold_clear", 64'(bus.busy), 64'(32'h1 << 15));
        drive_ld(5'd15, F3_LW, 2'd0, 32'h00001515);
        expect_wr(5'd15, 32'h00001515);
        tick();
        idle();
        check("sb_clear15", 64'(bus.busy), 64'd0);
        tick();

        // Reset mid-traffic discards hold and scoreboard
        drive_issue(5'd9);
        drive_alu(5'd3, 32'h00000003);
        drive_ld(5'd7, F3_LW, 2'd0, 32'h07070707);
        expect_wr(5'd3, 32'h00000003);
        tick();
        rst = 1'b1;
        bus.ld_issue_valid = 1'b0;
        drive_alu(5'd6, 32'h00000066);
        drive_ld(5'd4, F3_LW, 2'd0, 32'h04040404);
        tick();
        tick();
        rst = 1'b0;
        idle();
        check("midrst_we",    64'(bus.rf_we),        64'd0);
        check("midrst_busy",  64'(bus.busy),         64'd0);
        check("midrst_ready", 64'(bus.ld_rsp_ready), 64'd1);
        tick();
        check("midrst_hold_discard", 64'(bus.rf_we), 64'd0);

        // Counters: 3 ALU writes, 2 load writes, 4 stall cycles after a fresh reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        drive_alu(5'd1, 32'h000000A1);
        drive_ld(5'd2, F3_LW, 2'd0, 32'h000000B2);
        expect_wr(5'd1, 32'h000000A1);
        tick();
        drive_alu(5'd3, 32'h000000A3);
        drive_ld(5'd6, F3_LW, 2'd0, 32'h000000C6);
        expect_wr(5'd3, 32'h000000A3);
        tick();
        drive_alu(5'd0, 32'h000000A0);
        tick();
        drive_alu(5'd4, 32'h000000A4);
        expect_wr(5'd4, 32'h000000A4);
        tick();
        bus.alu_valid = 1'b0;
        expect_wr(5'd2, 32'h000000B2);
        tick();
        check("perf_ready_after_drain", 64'(bus.ld_rsp_ready), 64'd1);
        expect_wr(5'd6, 32'h000000C6);
        tick();
        idle();
        tick();
`ifdef WB_PERF_EN
        check("perf_alu_wr",   64'(bus.perf_alu_wr),   64'd3);
        check("perf_ld_wr",    64'(bus.perf_ld_wr),    64'd2);
        check("perf_ld_stall", 64'(bus.perf_ld_stall), 64'd4);
`else
        check("perf_alu_wr_tied",   64'(bus.perf_alu_wr),   64'd0);
        check("perf_ld_wr_tied",    64'(bus.perf_ld_wr),    64'd0);
        check("perf_ld_stall_tied", 64'(bus.perf_ld_stall), 64'd0);
`endif

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
